// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Purpose  : Two-requester round-robin front end for a single-port data RAM:
//            byte-lane stores, extended loads, error responses, 1-cycle latency.
// Revision : 1.0
// ============================================================================
module dm_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3072
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_unsigned,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_rsp_valid,
    output logic              m0_rsp_err,
    output logic [31:0]       m0_rsp_rdata,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic              m1_unsigned,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_rsp_valid,
    output logic              m1_rsp_err,
    output logic [31:0]       m1_rsp_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam logic [1:0]      c_size_byte = 2'b00;
    localparam logic [1:0]      c_size_half = 2'b01;
    localparam logic [1:0]      c_size_word = 2'b10;
    localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);

    logic              r_rr_last;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [31:0]       r_din_hold;
    logic              r_rsp_valid;
    logic              r_rsp_port;
    logic              r_rsp_we;
    logic [1:0]        r_rsp_size;
    logic [1:0]        r_rsp_off;
    logic              r_rsp_uns;
    logic              r_rsp_err;

    logic              w_gnt0, w_gnt1, w_any_gnt, w_legal, w_err;
    logic              w_we, w_uns;
    logic [1:0]        w_size, w_off;
    logic [31:0]       w_addr, w_wdata, w_din, w_rdata;
    logic [ADDR_W-1:0] w_widx;
    logic [3:0]        w_lanes;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // rr_last names the port that won most recently; the other one wins a tie.
    assign w_gnt0    = m0_valid & (~m1_valid | r_rr_last);
    assign w_gnt1    = m1_valid & (~m0_valid | ~r_rr_last);
    assign w_any_gnt = w_gnt0 | w_gnt1;
    assign m0_ready  = w_gnt0;
    assign m1_ready  = w_gnt1;

    assign w_we    = w_gnt1 ? m1_we       : m0_we;
    assign w_size  = w_gnt1 ? m1_size     : m0_size;
    assign w_uns   = w_gnt1 ? m1_unsigned : m0_unsigned;
    assign w_addr  = w_gnt1 ? m1_addr     : m0_addr;
    assign w_wdata = w_gnt1 ? m1_wdata    : m0_wdata;
    assign w_widx  = w_addr[ADDR_W+1:2];
    assign w_off   = w_addr[1:0];

    always_comb begin
        w_err = 1'b0;
        case (w_size)
            c_size_byte: w_err = 1'b0;
            c_size_half: w_err = w_off[0];
            c_size_word: w_err = |w_off;
            default:     w_err = 1'b1;
        endcase
        if ({1'b0, w_widx} >= c_depth) w_err = 1'b1;
        if (|w_addr[31:ADDR_W+2])      w_err = 1'b1;
    end

    assign w_legal = w_any_gnt & ~w_err;

    always_comb begin
        w_lanes = 4'b1111;
        w_din   = w_wdata;
        case (w_size)
            c_size_byte: begin
                w_lanes = 4'b0001 << w_off;
                w_din   = {4{w_wdata[7:0]}};
            end
            c_size_half: begin
                w_lanes = w_off[1] ? 4'b1100 : 4'b0011;
                w_din   = {2{w_wdata[15:0]}};
            end
            default: begin
                w_lanes = 4'b1111;
                w_din   = w_wdata;
            end
        endcase
    end

    // Address/data pins only move on legal grants so rejected requests never toggle the RAM bus.
    assign ram_en   = w_legal;
    assign ram_we   = (w_legal & w_we) ? w_lanes : 4'b0000;
    assign ram_addr = w_legal ? w_widx : r_addr_hold;
    assign ram_din  = w_legal ? w_din  : r_din_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last   <= 1'b1;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_size  <= 2'b00;
            r_rsp_off   <= 2'b00;
            r_rsp_uns   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_rr_last  <= w_gnt1;
                r_rsp_port <= w_gnt1;
                r_rsp_we   <= w_we;
                r_rsp_size <= w_size;
                r_rsp_off  <= w_off;
                r_rsp_uns  <= w_uns;
                r_rsp_err  <= w_err;
            end
            if (w_legal) begin
                r_addr_hold <= w_widx;
                r_din_hold  <= w_din;
            end
        end
    end

    always_comb begin
        case (r_rsp_off)
            2'd0:    w_byte = ram_dout[7:0];
            2'd1:    w_byte = ram_dout[15:8];
            2'd2:    w_byte = ram_dout[23:16];
            default: w_byte = ram_dout[31:24];
        endcase
        w_half = r_rsp_off[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (r_rsp_size)
            c_size_byte: w_rdata = {{24{~r_rsp_uns & w_byte[7]}}, w_byte};
            c_size_half: w_rdata = {{16{~r_rsp_uns & w_half[15]}}, w_half};
            default:     w_rdata = ram_dout;
        endcase
        if (!r_rsp_valid || r_rsp_we || r_rsp_err) w_rdata = 32'h0;
    end

    assign m0_rsp_valid = r_rsp_valid & ~r_rsp_port;
    assign m1_rsp_valid = r_rsp_valid &  r_rsp_port;
    assign m0_rsp_err   = m0_rsp_valid & r_rsp_err;
    assign m1_rsp_err   = m1_rsp_valid & r_rsp_err;
    assign m0_rsp_rdata = m0_rsp_valid ? w_rdata : 32'h0;
    assign m1_rsp_rdata = m1_rsp_valid ? w_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Purpose  : Vector table plus hand sequences, with a response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dm_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 3072;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_valid = 1'b0, m0_we = 1'b0, m0_unsigned = 1'b0;
    logic [1:0]        m0_size = 2'b00;
    logic [31:0]       m0_addr = 32'h0, m0_wdata = 32'h0;
    logic              m1_valid = 1'b0, m1_we = 1'b0, m1_unsigned = 1'b0;
    logic [1:0]        m1_size = 2'b00;
    logic [31:0]       m1_addr = 32'h0, m1_wdata = 32'h0;
    logic              m0_ready, m0_rsp_valid, m0_rsp_err;
    logic              m1_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0]       m0_rsp_rdata, m1_rsp_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout = 32'h0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_size(m0_size),
        .m0_unsigned(m0_unsigned), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_err(m0_rsp_err), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_size(m1_size),
        .m1_unsigned(m1_unsigned), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_err(m1_rsp_err), .m1_rsp_rdata(m1_rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Single-port RAM with registered read; preloaded on the first edge (held in reset).
    logic [31:0] mem [0:DEPTH-1];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            mem[0]       <= 32'h11223344;
            mem[4]       <= 32'h8899AABB;
            mem[8]       <= 32'hAAAAAAAA;
            mem[DEPTH-1] <= 32'hCAFEF00D;
            mem_init     <= 1'b1;
        end else if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sbq[$];

    task automatic push_exp(input logic port, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rdata; e.due = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic sb_step();
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
        end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check("rsp_valid_owner", e.port ? m1_rsp_valid : m0_rsp_valid, 32'd1);
            check("rsp_valid_other", e.port ? m0_rsp_valid : m1_rsp_valid, 32'd0);
            check("rsp_err",         e.port ? m1_rsp_err   : m0_rsp_err,   {31'd0, e.err});
            check("rsp_rdata",       e.port ? m1_rsp_rdata : m0_rsp_rdata, e.rdata);
        end else begin
            check("no_rsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        end
    endtask

    task automatic half_cyc();
        @(negedge clk);
        sb_step();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        if (!port) begin
            m0_valid = 1'b1; m0_we = we; m0_size = size; m0_unsigned = uns;
            m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_valid = 1'b1; m1_we = we; m1_size = size; m1_unsigned = uns;
            m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    typedef struct {
        logic        port, we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        logic        x_en, x_err;
        logic [3:0]  x_we;
        logic [11:0] x_raddr;
        logic [31:0] x_din, x_rdata;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic x_en, input logic [3:0] x_we, input logic [11:0] x_raddr,
                       input logic [31:0] x_din, input logic x_err, input logic [31:0] x_rdata);
        vec_t v;
        v.port = port; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.x_en = x_en; v.x_we = x_we; v.x_raddr = x_raddr; v.x_din = x_din;
        v.x_err = x_err; v.x_rdata = x_rdata;
        vecs.push_back(v);
    endtask

    initial begin
        //  port we size uns addr          wdata          en we      raddr    din           err rdata
        add(0, 0, 2'd2, 0, 32'h10,   32'h0,        1, 4'b0000, 12'h004, 32'h0,        0, 32'h8899AABB);
        add(0, 1, 2'd0, 0, 32'h13,   32'h5A,       1, 4'b1000, 12'h004, 32'h5A5A5A5A, 0, 32'h0);
        add(0, 0, 2'd0, 0, 32'h13,   32'h0,        1, 4'b0000, 12'h004, 32'h0,        0, 32'h0000005A);
        add(0, 1, 2'd0, 0, 32'h13,   32'hF0,       1, 4'b1000, 12'h004, 32'hF0F0F0F0, 0, 32'h0);
        add(0, 0, 2'd0, 0, 32'h13,   32'h0,        1, 4'b0000, 12'h004, 32'h0,        0, 32'hFFFFFFF0);
        add(0, 0, 2'd0, 1, 32'h13,   32'h0,        1, 4'b0000, 12'h004, 32'h0,        0, 32'h000000F0);
        add(0, 0, 2'd0, 1, 32'h11,   32'h0,        1, 4'b0000, 12'h004, 32'h0,        0, 32'h000000AA);
        add(0, 0, 2'd0, 0, 32'h12,   32'h0,        1, 4'b0000, 12'h004, 32'h0,        0, 32'hFFFFFF99);
        add(1, 0, 2'd1, 0, 32'h21,   32'h0,        0, 4'b0000, 12'h000, 32'h0,        1, 32'h0);
        add(1, 0, 2'd2, 0, 32'h3000, 32'h0,        0, 4'b0000, 12'h000, 32'h0,        1, 32'h0);
        add(0, 1, 2'd1, 0, 32'h22,   32'h1234,     1, 4'b1100, 12'h008, 32'h12341234, 0, 32'h0);
        add(0, 0, 2'd2, 0, 32'h20,   32'h0,        1, 4'b0000, 12'h008, 32'h0,        0, 32'h1234AAAA);
        add(1, 0, 2'd1, 0, 32'h20,   32'h0,        1, 4'b0000, 12'h008, 32'h0,        0, 32'hFFFFAAAA);
        add(1, 0, 2'd1, 1, 32'h22,   32'h0,        1, 4'b0000, 12'h008, 32'h0,        0, 32'h00001234);
        add(0, 0, 2'd3, 0, 32'h0,    32'h0,        0, 4'b0000, 12'h000, 32'h0,        1, 32'h0);
        add(0, 0, 2'd2, 0, 32'h4000, 32'h0,        0, 4'b0000, 12'h000, 32'h0,        1, 32'h0);
        add(1, 1, 2'd2, 0, 32'h2FFC, 32'h01020304, 1, 4'b1111, 12'hBFF, 32'h01020304, 0, 32'h0);
        add(0, 0, 2'd2, 0, 32'h2FFC, 32'h0,        1, 4'b0000, 12'hBFF, 32'h0,        0, 32'h01020304);
        add(1, 1, 2'd2, 0, 32'h2,    32'hDEADBEEF, 0, 4'b0000, 12'h000, 32'h0,        1, 32'h0);
        add(0, 0, 2'd2, 0, 32'h0,    32'h0,        1, 4'b0000, 12'h000, 32'h0,        0, 32'h11223344);
        add(0, 1, 2'd0, 0, 32'h0,    32'h1FF,      1, 4'b0001, 12'h000, 32'hFFFFFFFF, 0, 32'h0);
        add(0, 0, 2'd1, 0, 32'h0,    32'h0,        1, 4'b0000, 12'h000, 32'h0,        0, 32'h000033FF);
        add(0, 0, 2'd0, 0, 32'h0,    32'h0,        1, 4'b0000, 12'h000, 32'h0,        0, 32'hFFFFFFFF);
        add(0, 1, 2'd1, 0, 32'h0,    32'hABCD8001, 1, 4'b0011, 12'h000, 32'h80018001, 0, 32'h0);
        add(0, 0, 2'd2, 0, 32'h0,    32'h0,        1, 4'b0000, 12'h000, 32'h0,        0, 32'h11228001);
        add(1, 1, 2'd0, 0, 32'h12,   32'h77,       1, 4'b0100, 12'h004, 32'h77777777, 0, 32'h0);
        add(1, 0, 2'd2, 0, 32'h2FFF, 32'h0,        0, 4'b0000, 12'h000, 32'h0,        1, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m0_ready", m0_ready, 32'd0);
        check("rst_m1_ready", m1_ready, 32'd0);
        check("rst_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        check("rst_rsp_err", {30'd0, m1_rsp_err, m0_rsp_err}, 32'd0);
        check("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
        check("rst_ram_en", ram_en, 32'd0);
        check("rst_ram_we", ram_we, 32'd0);
        rst_n = 1'b1;
        next_cyc();

        // Back-to-back table vectors, one per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            half_cyc();
            check($sformatf("v%0d_ready", i), vecs[i].port ? m1_ready : m0_ready, 32'd1);
            check($sformatf("v%0d_ram_en", i), ram_en, {31'd0, vecs[i].x_en});
            check($sformatf("v%0d_ram_we", i), ram_we, {28'd0, vecs[i].x_we});
            if (vecs[i].x_en)
                check($sformatf("v%0d_ram_addr", i), ram_addr, {20'd0, vecs[i].x_raddr});
            if (vecs[i].x_we != 4'b0000)
                check($sformatf("v%0d_ram_din", i), ram_din, vecs[i].x_din);
            push_exp(vecs[i].port, vecs[i].x_err, vecs[i].x_rdata);
            next_cyc();
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        half_cyc();
        check("idle_ram_en", ram_en, 32'd0);
        check("idle_ram_we", ram_we, 32'd0);
        next_cyc();

        // Reset lands between grant and response: the response must vanish
        drive(0, 0, 2'd2, 0, 32'h10, 32'h0);
        half_cyc();
        check("rst_mid_ready", m0_ready, 32'd1);
        push_exp(1'b0, 1'b0, 32'hF077AABB);
        #2 rst_n = 1'b0;
        next_cyc();
        m0_valid = 1'b0;
        half_cyc();
        check("rst_mid_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        check("rst_mid_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
        check("rst_mid_ram_en", ram_en, 32'd0);
        check("rst_mid_ram_we", ram_we, 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) begin
            next_cyc();
            half_cyc();
        end
        next_cyc();

        // Both ports streaming: port 0 wins the first conflict after reset, then alternation
        drive(0, 0, 2'd2, 0, 32'h10, 32'h0);
        m1_valid = 1'b1; m1_we = 1'b0; m1_size = 2'd2; m1_unsigned = 1'b0;
        m1_addr = 32'h2FFC; m1_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = k[0];
            half_cyc();
            check($sformatf("arb%0d_m0_ready", k), m0_ready, {31'd0, ~g});
            check($sformatf("arb%0d_m1_ready", k), m1_ready, {31'd0, g});
            check($sformatf("arb%0d_ram_addr", k), ram_addr, g ? 32'hBFF : 32'h004);
            push_exp(g, 1'b0, g ? 32'h01020304 : 32'hF077AABB);
            next_cyc();
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        repeat (2) begin
            half_cyc();
            next_cyc();
        end
        check("sb_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
